// File: rtl/spi_frame_receiver.sv
// ============================================================================
// Module      : spi_frame_receiver
// Description : SPI slave receiver for [ADDR | DATA] control frames. SCLK, CS_n
//               and SDO are synchronised into CLK_50Mhz and updates are written
//               into one of 2**ADDR_BITS channel registers.
//               Optional feature macro: SPI_RX_PARITY_EN (trailing even-parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_receiver #(
  parameter int ADDR_BITS   = 2,
  parameter int DATA_BITS   = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                  CLK_50Mhz,
  input  logic                                  reset,
  input  logic                                  spi_sclk,
  input  logic                                  spi_cs_n,
  input  logic                                  spi_sdo,
  output logic [(2**ADDR_BITS)*DATA_BITS-1:0]   ch_data,
  output logic [(2**ADDR_BITS)-1:0]             ch_valid,
  output logic                                  frame_ok,
  output logic                                  frame_err,
  output logic                                  busy,
  output logic [15:0]                           frame_count
);

  localparam int c_NUM_CH = 2**ADDR_BITS;
`ifdef SPI_RX_PARITY_EN
  localparam int c_FRAME_BITS = ADDR_BITS + DATA_BITS + 1;
`else
  localparam int c_FRAME_BITS = ADDR_BITS + DATA_BITS;
`endif
  localparam int c_CNT_W = $clog2(c_FRAME_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]    r_sclk_sync, r_cs_sync, r_sdo_sync;
  logic                      r_sclk_d, r_cs_d;
  logic [SYNC_STAGES:0]      r_warm;
  logic [c_FRAME_BITS-1:0]   r_shift;
  logic [c_CNT_W-1:0]        r_cnt;
  logic                      r_ovf;
  logic [DATA_BITS-1:0]      r_ch [c_NUM_CH];
  logic [c_NUM_CH-1:0]       r_ch_valid;
  logic                      r_frame_ok, r_frame_err;
  logic [15:0]               r_frame_count;

  logic                      w_sclk_s, w_cs_s, w_sdo_s;
  logic                      w_sclk_rise, w_cs_rise, w_cs_fall;
  logic                      w_parity_ok, w_accept, w_do_write;
  logic [ADDR_BITS-1:0]      w_addr;
  logic [DATA_BITS-1:0]      w_data;
  logic [c_NUM_CH-1:0]       w_ch_we;

  // Edges are masked until the pipeline holds real samples, so a CS_n already
  // low at reset release never looks like a falling edge.
  always_ff @(posedge CLK_50Mhz) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sdo_sync  <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_warm      <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sdo_sync  <= {r_sdo_sync[SYNC_STAGES-2:0], spi_sdo};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdo_s     = r_sdo_sync[SYNC_STAGES-1];
  assign w_sclk_rise = r_warm[SYNC_STAGES] &  w_sclk_s & ~r_sclk_d;
  assign w_cs_rise   = r_warm[SYNC_STAGES] &  w_cs_s   & ~r_cs_d;
  assign w_cs_fall   = r_warm[SYNC_STAGES] & ~w_cs_s   &  r_cs_d;

`ifdef SPI_RX_PARITY_EN
  assign w_parity_ok = ~^r_shift;
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_addr     = r_shift[c_FRAME_BITS-1 -: ADDR_BITS];
  assign w_data     = r_shift[c_FRAME_BITS-1-ADDR_BITS -: DATA_BITS];
  assign w_accept   = (r_cnt == c_CNT_W'(c_FRAME_BITS)) && !r_ovf && w_parity_ok;
  assign w_do_write = (r_state == S_CHECK) && w_accept;

  always_ff @(posedge CLK_50Mhz) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_cs_rise) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50Mhz) begin
    if (reset) begin
      r_shift       <= '0;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_ch_valid    <= '0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_ch_valid  <= w_ch_we;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        // A CS_n rise in the same cycle as an SCLK rise drops the SCLK edge.
        S_SHIFT: begin
          if (!w_cs_rise && w_sclk_rise) begin
            if (r_cnt == c_CNT_W'(c_FRAME_BITS)) begin
              r_ovf <= 1'b1;
            end else begin
              r_shift <= {r_shift[c_FRAME_BITS-2:0], w_sdo_s};
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_frame_ok    <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end else begin
            r_frame_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < c_NUM_CH; k++) begin : g_ch
    assign w_ch_we[k] = w_do_write && (w_addr == ADDR_BITS'(k));

    always_ff @(posedge CLK_50Mhz) begin
      if (reset)           r_ch[k] <= '0;
      else if (w_ch_we[k]) r_ch[k] <= w_data;
    end

    assign ch_data[k*DATA_BITS +: DATA_BITS] = r_ch[k];
  end

  assign ch_valid    = r_ch_valid;
  assign frame_ok    = r_frame_ok;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state == S_SHIFT);
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_receiver.sv
// ============================================================================
// Module      : tb_spi_frame_receiver
// Description : Scoreboard bench for spi_frame_receiver (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_receiver;

`ifdef SPI_RX_PARITY_EN
  localparam int FB = 17;
`else
  localparam int FB = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        sdo = 1'b0;
  logic [55:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_ok, frame_err, busy;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic        ok;
    logic [1:0]  addr;
    logic [13:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] model_ch[4];
  logic [15:0] model_cnt;

  spi_frame_receiver dut (
    .CLK_50Mhz  (clk),
    .reset      (rst),
    .spi_sclk   (sclk),
    .spi_cs_n   (cs_n),
    .spi_sdo    (sdo),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .busy       (busy),
    .frame_count(frame_count)
  );

  always #10 clk = ~clk;

  // Scoreboard: every result pulse pops one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_ok === 1'b1 || frame_err === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: ok=%b err=%b required none", frame_ok, frame_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (frame_ok !== e.ok || frame_err !== !e.ok) begin
            errors++;
            $display("FAIL frame_result: ok=%b err=%b required ok=%b", frame_ok, frame_err, e.ok);
          end else if (e.ok && (ch_valid !== (4'b0001 << e.addr) ||
                                ch_data[e.addr*14 +: 14] !== e.data)) begin
            errors++;
            $display("FAIL ch_update: valid=%b data=%h required valid=%b data=%h",
                     ch_valid, ch_data[e.addr*14 +: 14], 4'b0001 << e.addr, e.data);
          end else if (!e.ok && ch_valid !== 4'b0) begin
            errors++;
            $display("FAIL err_valid: valid=%b required 0000", ch_valid);
          end
        end
      end else if (ch_valid !== 4'b0) begin
        checks++;
        errors++;
        $display("FAIL stray_valid: valid=%b required 0000", ch_valid);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [15:0] v);
`ifdef SPI_RX_PARITY_EN
    return {15'd0, v, ^v};
`else
    return {16'd0, v};
`endif
  endfunction

  task automatic expect_frame(input logic [31:0] bits, input int n);
    exp_t e;
    e.ok   = (n == FB);
`ifdef SPI_RX_PARITY_EN
    e.ok   = e.ok && (^bits[FB-1:0] == 1'b0);
`endif
    e.addr = bits[FB-1 -: 2];
    e.data = bits[FB-3 -: 14];
    if (e.ok) begin
      model_ch[e.addr] = e.data;
      model_cnt++;
    end
    sb.push_back(e);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b);
    sdo = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    cs_low();
    for (int i = n - 1; i >= 0; i--) sclk_bit(bits[i]);
    cs_high();
  endtask

  function automatic logic [55:0] model_vec();
    logic [55:0] v;
    for (int k = 0; k < 4; k++) v[k*14 +: 14] = model_ch[k];
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ch_data !== 56'd0 || ch_valid !== 4'd0 || frame_ok !== 1'b0 ||
        frame_err !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_during: data=%h valid=%b ok=%b err=%b busy=%b cnt=%0d required all 0",
               ch_data, ch_valid, frame_ok, frame_err, busy, frame_count);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (ch_data !== 56'd0 || busy !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_after: data=%h busy=%b cnt=%0d required 0", ch_data, busy, frame_count);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] bits;
    int k;
    bits = mk(16'h4100);
    expect_frame(bits, FB);
    cs_low();
    for (int i = FB - 1; i >= 0; i--) begin
      sclk_bit(bits[i]);
      if (i == 8) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_frame: busy=%b required 1", busy);
        end
      end
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    k = 0;
    while (frame_ok !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL latency: cycles=%0d required 4", k);
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || ch_data !== model_vec() || frame_count !== model_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_frame: pending=%0d data=%h cnt=%0d busy=%b required data=%h cnt=%0d busy=0",
               sb.size(), ch_data, frame_count, busy, model_vec(), model_cnt);
      sb.delete();
    end
  endtask

  task automatic test_short_frame();
    logic [31:0] bits;
    bits = mk(16'hC321) >> 1;
    repeat (6) @(negedge clk);
    expect_frame(bits, FB - 1);
    send_frame(bits, FB - 1);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || ch_data !== model_vec() || frame_count !== model_cnt) begin
      errors++;
      $display("FAIL short_frame: pending=%0d data=%h cnt=%0d required data=%h cnt=%0d",
               sb.size(), ch_data, frame_count, model_vec(), model_cnt);
      sb.delete();
    end
  endtask

  task automatic test_overflow();
    logic [31:0] bits;
    bits = {mk(16'h8ABC), 1'b1};
    repeat (6) @(negedge clk);
    expect_frame(bits, FB + 1);
    send_frame(bits, FB + 1);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || ch_data !== model_vec() || frame_count !== model_cnt) begin
      errors++;
      $display("FAIL overflow: pending=%0d data=%h cnt=%0d required data=%h cnt=%0d",
               sb.size(), ch_data, frame_count, model_vec(), model_cnt);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    repeat (6) @(negedge clk);
    expect_frame(mk(16'h0005), FB);
    send_frame(mk(16'h0005), FB);
    repeat (4) @(negedge clk);
    expect_frame(mk(16'hFFFF), FB);
    send_frame(mk(16'hFFFF), FB);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || ch_data[13:0] !== 14'h0005 || ch_data[55:42] !== 14'h3FFF ||
        ch_data !== model_vec() || frame_count !== model_cnt) begin
      errors++;
      $display("FAIL back_to_back: pending=%0d data=%h cnt=%0d required data=%h cnt=%0d",
               sb.size(), ch_data, frame_count, model_vec(), model_cnt);
      sb.delete();
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] bits;
    bits = mk(16'h8AAA);
    repeat (6) @(negedge clk);
    cs_low();
    for (int i = FB - 1; i >= FB - 8; i--) sclk_bit(bits[i]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) model_ch[k] = 14'd0;
    model_cnt = 16'd0;
    for (int i = FB - 9; i >= 0; i--) sclk_bit(bits[i]);
    cs_high();
    repeat (12) @(negedge clk);
    checks++;
    if (ch_data !== 56'd0 || frame_count !== 16'd0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL reset_midframe: data=%h cnt=%0d busy=%b required 0",
               ch_data, frame_count, busy);
      sb.delete();
    end
    expect_frame(mk(16'h8155), FB);
    send_frame(mk(16'h8155), FB);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || ch_data[41:28] !== 14'h0155 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL after_reset_frame: pending=%0d ch2=%h cnt=%0d required ch2=0155 cnt=1",
               sb.size(), ch_data[41:28], frame_count);
      sb.delete();
    end
  endtask

`ifdef SPI_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] bits;
    bits = mk(16'h4ACE) ^ 32'd1;
    repeat (6) @(negedge clk);
    expect_frame(bits, FB);
    send_frame(bits, FB);
    expect_frame(mk(16'h4ACE), FB);
    repeat (4) @(negedge clk);
    send_frame(mk(16'h4ACE), FB);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || ch_data !== model_vec() || ch_data[27:14] !== 14'h0ACE ||
        frame_count !== model_cnt) begin
      errors++;
      $display("FAIL parity: pending=%0d data=%h cnt=%0d required data=%h cnt=%0d",
               sb.size(), ch_data, frame_count, model_vec(), model_cnt);
      sb.delete();
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 4; k++) model_ch[k] = 14'd0;
    model_cnt = 16'd0;
    test_reset();
    test_single_frame();
    test_short_frame();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
`ifdef SPI_RX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
